// File: rtl/note_sequencer_if.sv
// Handshake/bus bundle between a note_sequencer voice, its pattern/delta ROMs
// and the phase_generator it feeds.
interface note_sequencer_if #(
    parameter int STEP_BITS = 4,
    parameter int NOTE_BITS = 6,
    parameter int DUR_BITS  = 8
);
    logic                          i_start;
    logic                          i_stop;
    logic                          i_loop;
    logic                          i_tick;
    logic [STEP_BITS-1:0]          o_step_addr;
    logic [NOTE_BITS+DUR_BITS-1:0] i_step_data;
    logic [NOTE_BITS-1:0]          o_note_addr;
    logic [31:0]                   i_note_delta;
    logic [31:0]                   o_phase_delta;
    logic                          o_phase_delta_valid;
    logic                          o_busy;
    logic                          o_done;

    modport slave (
        input  i_start, i_stop, i_loop, i_tick, i_step_data, i_note_delta,
        output o_step_addr, o_note_addr, o_phase_delta, o_phase_delta_valid,
               o_busy, o_done
    );

    modport master (
        output i_start, i_stop, i_loop, i_tick, i_step_data, i_note_delta,
        input  o_step_addr, o_note_addr, o_phase_delta, o_phase_delta_valid,
               o_busy, o_done
    );
endinterface

// File: rtl/note_sequencer.sv
// Walks a {note,duration} pattern ROM, looks each note up in a phase-delta
// table and strobes the delta into one phase_generator voice per step.
module note_sequencer #(
    parameter int STEP_BITS = 4,
    parameter int NOTE_BITS = 6,
    parameter int DUR_BITS  = 8
) (
    input  logic            i_clk,
    input  logic            i_rst,
    note_sequencer_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_LATCH  = 3'd2,
        S_LOOKUP = 3'd3,
        S_LOAD   = 3'd4,
        S_HOLD   = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    localparam logic [STEP_BITS-1:0] LAST_STEP = {STEP_BITS{1'b1}};
    localparam logic [DUR_BITS-1:0]  ONE_TICK  = DUR_BITS'(1);

    state_t                r_state;
    logic [STEP_BITS-1:0]  r_step_addr;
    logic [NOTE_BITS-1:0]  r_note_addr;
    logic [NOTE_BITS-1:0]  r_note;
    logic [DUR_BITS-1:0]   r_dur;
    logic [DUR_BITS-1:0]   r_counter;
    logic [31:0]           r_phase_delta;
    logic                  r_valid;
    logic                  r_busy;
    logic                  r_done;

    logic [NOTE_BITS-1:0]  w_step_note;
    logic [DUR_BITS-1:0]   w_step_dur;

    assign w_step_note = bus.i_step_data[NOTE_BITS+DUR_BITS-1:DUR_BITS];
    assign w_step_dur  = bus.i_step_data[DUR_BITS-1:0];

    assign bus.o_step_addr         = r_step_addr;
    assign bus.o_note_addr         = r_note_addr;
    assign bus.o_phase_delta       = r_phase_delta;
    assign bus.o_phase_delta_valid = r_valid;
    assign bus.o_busy              = r_busy;
    assign bus.o_done              = r_done;

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= S_IDLE;
            r_step_addr   <= {STEP_BITS{1'b0}};
            r_note_addr   <= {NOTE_BITS{1'b0}};
            r_note        <= {NOTE_BITS{1'b0}};
            r_dur         <= {DUR_BITS{1'b0}};
            r_counter     <= {DUR_BITS{1'b0}};
            r_phase_delta <= 32'd0;
            r_valid       <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_done  <= 1'b0;
            if ((r_state != S_IDLE) && bus.i_stop) begin
                // DONE already carries delta 0 and a strobe, so no second strobe there.
                r_state       <= S_IDLE;
                r_busy        <= 1'b0;
                r_phase_delta <= 32'd0;
                r_valid       <= (r_state != S_DONE);
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (bus.i_start) begin
                            r_step_addr <= {STEP_BITS{1'b0}};
                            r_busy      <= 1'b1;
                            r_state     <= S_FETCH;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                    S_FETCH: r_state <= S_LATCH;
                    S_LATCH: begin
                        r_note <= w_step_note;
                        r_dur  <= w_step_dur;
                        if (w_step_dur != {DUR_BITS{1'b0}}) begin
                            r_note_addr <= w_step_note;
                            r_state     <= S_LOOKUP;
                        end else if (bus.i_loop) begin
                            r_step_addr <= {STEP_BITS{1'b0}};
                            r_state     <= S_FETCH;
                        end else begin
                            r_phase_delta <= 32'd0;
                            r_valid       <= 1'b1;
                            r_done        <= 1'b1;
                            r_state       <= S_DONE;
                        end
                    end
                    S_LOOKUP: r_state <= S_LOAD;
                    S_LOAD: begin
                        r_phase_delta <= (r_note == {NOTE_BITS{1'b0}}) ? 32'd0 : bus.i_note_delta;
                        r_valid       <= 1'b1;
                        r_counter     <= r_dur;
                        r_state       <= S_HOLD;
                    end
                    S_HOLD: begin
                        if (!bus.i_tick) begin
                            r_state <= S_HOLD;
                        end else if (r_counter != ONE_TICK) begin
                            r_counter <= r_counter - ONE_TICK;
                        end else if (r_step_addr != LAST_STEP) begin
                            r_step_addr <= r_step_addr + {{(STEP_BITS-1){1'b0}}, 1'b1};
                            r_state     <= S_FETCH;
                        end else if (bus.i_loop) begin
                            r_step_addr <= {STEP_BITS{1'b0}};
                            r_state     <= S_FETCH;
                        end else begin
                            r_phase_delta <= 32'd0;
                            r_valid       <= 1'b1;
                            r_done        <= 1'b1;
                            r_state       <= S_DONE;
                        end
                    end
                    S_DONE: begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                    default: begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end
endmodule
